pe_line_sequencer: RTL and testbench



---
 rtl/pe_pkg.sv | 18 +
 rtl/pe_line_sequencer.sv | 156 +++++++++++++++
 tb/tb_pe_line_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_pkg.sv
// Shared definitions for the priority-evaluation sequencer and datapath:
// the sequencer state encoding and the default line geometry.
package pe_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRIME = 3'd1,
    P0    = 3'd2,
    P1    = 3'd3,
    P2    = 3'd4,
    P3    = 3'd5,
    DRAIN = 3'd6
  } pe_seq_state_t;

  localparam int unsigned PE_LINE_PIXELS  = 240;
  localparam int unsigned PE_PRIME_CYCLES = 2;

endpackage

// File: rtl/pe_line_sequencer.sv
// Per-scanline controller: primes the datapath, steps the four-phase per-pixel
// address/read sequence across a line, and flips the ping-pong buffer per line.
module pe_line_sequencer
  import pe_pkg::*;
#(
  parameter int unsigned LINE_PIXELS  = PE_LINE_PIXELS,
  parameter int unsigned PRIME_CYCLES = PE_PRIME_CYCLES
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       line_start,
  input  logic [7:0] vcount,
  input  logic       enable,
  input  logic       stall,
  output logic [7:0] col,
  output logic [7:0] line_num,
  output logic       buf_sel,
  output logic       clear,
  output logic       send_address_1,
  output logic       send_address_2,
  output logic       read_data_1,
  output logic       read_data_2,
  output logic       pixel_valid,
  output logic       line_busy,
  output logic       line_done,
  output logic       overrun
);

  localparam logic [7:0] LAST_COL   = 8'(LINE_PIXELS - 1);
  localparam logic [7:0] PRIME_LAST = 8'(PRIME_CYCLES - 1);

  pe_seq_state_t state_q, state_d;
  logic [7:0]    col_q, col_d;
  logic [7:0]    line_num_q, line_num_d;
  logic [7:0]    prime_q, prime_d;
  logic          buf_sel_q, buf_sel_d;
  logic          overrun_q, overrun_d;

  // State and counter registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      col_q      <= 8'd0;
      line_num_q <= 8'd0;
      prime_q    <= 8'd0;
      buf_sel_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      line_num_q <= line_num_d;
      prime_q    <= prime_d;
      buf_sel_q  <= buf_sel_d;
      overrun_q  <= overrun_d;
    end
  end

  // Next-state logic; a line_start outranks stall and the DRAIN exit
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    line_num_d = line_num_q;
    prime_d    = prime_q;
    buf_sel_d  = buf_sel_q;
    overrun_d  = 1'b0;
    if (line_start) begin
      overrun_d = (state_q != IDLE);
      if (enable) begin
        state_d    = PRIME;
        col_d      = 8'd0;
        line_num_d = vcount;
        buf_sel_d  = ~buf_sel_q;
        prime_d    = 8'd0;
      end else begin
        state_d = IDLE;
      end
    end else begin
      case (state_q)
        IDLE:  state_d = IDLE;
        PRIME: begin
          if (prime_q == PRIME_LAST) begin
            state_d = P0;
          end else begin
            prime_d = prime_q + 8'd1;
          end
        end
        P0: begin
          if (stall) state_d = P0;
          else       state_d = P1;
        end
        P1: begin
          if (stall) state_d = P1;
          else       state_d = P2;
        end
        P2: begin
          if (stall) state_d = P2;
          else       state_d = P3;
        end
        P3: begin
          if (stall) begin
            state_d = P3;
          end else if (col_q == LAST_COL) begin
            state_d = DRAIN;
          end else begin
            col_d   = col_q + 8'd1;
            state_d = P0;
          end
        end
        DRAIN:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output decode from registered state; stall only masks the pixel-phase strobes
  always_comb begin
    clear          = 1'b0;
    send_address_1 = 1'b0;
    send_address_2 = 1'b0;
    read_data_1    = 1'b0;
    read_data_2    = 1'b0;
    pixel_valid    = 1'b0;
    line_busy      = 1'b1;
    line_done      = 1'b0;
    case (state_q)
      IDLE: begin
        clear     = 1'b1;
        line_busy = 1'b0;
      end
      PRIME: clear = 1'b1;
      P0:    read_data_2 = ~stall;
      P1:    clear = 1'b0;
      P2:    send_address_1 = ~stall;
      P3: begin
        send_address_2 = ~stall;
        read_data_1    = ~stall;
        clear          = ~stall;
        pixel_valid    = ~stall;
      end
      DRAIN: begin
        read_data_2 = 1'b1;
        line_done   = 1'b1;
      end
      default: begin
        clear     = 1'b1;
        line_busy = 1'b0;
      end
    endcase
  end

  assign col      = col_q;
  assign line_num = line_num_q;
  assign buf_sel  = buf_sel_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_pe_line_sequencer.sv
// Randomised self-checking bench for pe_line_sequencer against a pixel-phase-index
// reference model of a scanline pass.
module tb_pe_line_sequencer;

  localparam int L  = 240;
  localparam int PC = 2;
  localparam int M_IDLE = 0, M_PRIME = 1, M_PIX = 2, M_DRAIN = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       line_start = 1'b0, enable = 1'b0, stall = 1'b0;
  logic [7:0] vcount = 8'd0;
  logic [7:0] col, line_num;
  logic       buf_sel, clear, send_address_1, send_address_2, read_data_1, read_data_2;
  logic       pixel_valid, line_busy, line_done, overrun;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // reference model: mode, cycles spent priming, linear pixel-phase index (4 per column)
  int         m_mode, m_prime, m_k, m_col;
  logic [7:0] m_line;
  logic       m_buf, m_ovr;

  pe_line_sequencer #(.LINE_PIXELS(L), .PRIME_CYCLES(PC)) dut (
    .clock(clock), .reset(reset), .line_start(line_start), .vcount(vcount),
    .enable(enable), .stall(stall), .col(col), .line_num(line_num), .buf_sel(buf_sel),
    .clear(clear), .send_address_1(send_address_1), .send_address_2(send_address_2),
    .read_data_1(read_data_1), .read_data_2(read_data_2), .pixel_valid(pixel_valid),
    .line_busy(line_busy), .line_done(line_done), .overrun(overrun)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // bit map: col[25:18] line[17:10] buf9 clear8 sa1 7 sa2 6 rd1 5 rd2 4 pv3 busy2 done1 ovr0
  function automatic logic [25:0] obs_vec();
    return {col, line_num, buf_sel, clear, send_address_1, send_address_2,
            read_data_1, read_data_2, pixel_valid, line_busy, line_done, overrun};
  endfunction

  function automatic logic [25:0] model_out(input logic st);
    logic [7:0] c;
    logic clr, sa1, sa2, rd1, rd2, pv, busy, done;
    c = 8'd0; clr = 1'b0; sa1 = 1'b0; sa2 = 1'b0; rd1 = 1'b0; rd2 = 1'b0;
    pv = 1'b0; busy = 1'b1; done = 1'b0;
    case (m_mode)
      M_IDLE:  begin c = 8'(m_col); clr = 1'b1; busy = 1'b0; end
      M_PRIME: clr = 1'b1;
      M_PIX: begin
        c = 8'(m_k / 4);
        if (!st) begin
          case (m_k % 4)
            0: rd2 = 1'b1;
            2: sa1 = 1'b1;
            3: begin sa2 = 1'b1; rd1 = 1'b1; clr = 1'b1; pv = 1'b1; end
            default: ;
          endcase
        end
      end
      default: begin c = 8'(L - 1); rd2 = 1'b1; done = 1'b1; end
    endcase
    return {c, m_line, m_buf, clr, sa1, sa2, rd1, rd2, pv, busy, done, m_ovr};
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_prime = 0; m_k = 0; m_col = 0;
    m_line = 8'd0; m_buf = 1'b0; m_ovr = 1'b0;
  endtask

  task automatic model_step(input logic ls, input logic en, input logic [7:0] vc, input logic st);
    m_ovr = 1'b0;
    if (ls) begin
      m_ovr = (m_mode != M_IDLE);
      if (en) begin
        m_mode = M_PRIME; m_prime = 0; m_line = vc; m_buf = ~m_buf; m_col = 0;
      end else begin
        if (m_mode == M_PIX) m_col = m_k / 4;
        else if (m_mode == M_DRAIN) m_col = L - 1;
        else if (m_mode == M_PRIME) m_col = 0;
        m_mode = M_IDLE;
      end
    end else begin
      case (m_mode)
        M_PRIME: begin
          m_prime++;
          if (m_prime == PC) begin m_mode = M_PIX; m_k = 0; end
        end
        M_PIX: if (!st) begin
          if (m_k == 4 * L - 1) m_mode = M_DRAIN;
          else m_k++;
        end
        M_DRAIN: begin m_mode = M_IDLE; m_col = L - 1; end
        default: ;
      endcase
    end
  endtask

  // one clock: drive at negedge, sample observed/expected, advance model at posedge
  task automatic step(input logic ls, input logic en, input logic [7:0] vc, input logic st,
                      output logic [25:0] o, output logic [25:0] e, output int c);
    @(negedge clock);
    line_start = ls; enable = en; vcount = vc; stall = st;
    #1;
    o = obs_vec();
    e = model_out(st);
    c = cyc;
    @(posedge clock);
    model_step(ls, en, vc, st);
  endtask

  task automatic test_reset();
    logic [25:0] o, e;
    int c;
    reset = 1'b1;
    model_reset();
    repeat (3) @(negedge clock);
    #1;
    n_checks++;
    if (obs_vec() !== 26'h0000100) begin
      n_fail++; $display("FAIL reset_values got=%h exp=%h", obs_vec(), 26'h0000100);
    end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 8'd0, 1'b0, o, e, c);
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL reset_idle cyc=%0d got=%h exp=%h", c, o, e); end
    end
  endtask

  task automatic run_line(input string tag, input logic [7:0] vc, input int stall_k,
                          input int stall_len, input bit rnd);
    logic [25:0] o, e;
    int c, t0, stalls, npv, ndone, left;
    logic st, en, exp_buf;
    bit fin;
    exp_buf = ~m_buf;
    step(1'b1, 1'b1, vc, 1'b0, o, e, t0);
    n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL %s_accept cyc=%0d got=%h exp=%h", tag, t0, o, e); end
    stalls = 0; npv = 0; ndone = 0; left = stall_len; fin = 1'b0;
    for (int i = 0; i < 4 * L + PC + 600 && !fin; i++) begin
      st = 1'b0;
      if (m_mode == M_PIX && m_k == stall_k && left > 0) begin st = 1'b1; left--; end
      else if (rnd && $urandom_range(0, 5) == 0) st = 1'b1;
      en = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (st && m_mode == M_PIX) stalls++;
      step(1'b0, en, 8'($urandom_range(0, 255)), st, o, e, c);
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL %s_cycle cyc=%0d got=%h exp=%h", tag, c, o, e); end
      if (o[3]) begin
        n_checks++;
        if (c !== t0 + PC + 4 + 4 * npv + stalls) begin
          n_fail++;
          $display("FAIL %s_pv_time col=%0d cyc=%0d exp=%0d", tag, npv, c, t0 + PC + 4 + 4 * npv + stalls);
        end
        npv++;
      end
      if (o[1]) begin
        n_checks++;
        if (c !== t0 + PC + 4 * L + 1 + stalls) begin
          n_fail++; $display("FAIL %s_done_time cyc=%0d exp=%0d", tag, c, t0 + PC + 4 * L + 1 + stalls);
        end
        ndone++;
      end
      if (ndone > 0 && m_mode == M_IDLE) fin = 1'b1;
    end
    n_checks++;
    if (!fin) begin n_fail++; $display("FAIL %s_timeout got=running exp=idle", tag); end
    n_checks++;
    if (npv !== L) begin n_fail++; $display("FAIL %s_pv_count got=%0d exp=%0d", tag, npv, L); end
    n_checks++;
    if (ndone !== 1) begin n_fail++; $display("FAIL %s_done_count got=%0d exp=1", tag, ndone); end
    n_checks++;
    if (line_num !== vc || buf_sel !== exp_buf) begin
      n_fail++; $display("FAIL %s_latch got=%h/%b exp=%h/%b", tag, line_num, buf_sel, vc, exp_buf);
    end
  endtask

  task automatic test_basic();
    run_line("basic", 8'd37, -1, 0, 1'b0);
  endtask

  task automatic test_stall();
    run_line("stall", 8'd38, 41, 3, 1'b0);
  endtask

  task automatic test_random_stall();
    for (int n = 0; n < 2; n++) run_line("rand", 8'($urandom_range(0, 255)), -1, 0, 1'b1);
  endtask

  task automatic test_disabled();
    logic [25:0] o, e;
    int c, ndone;
    logic b;
    b = buf_sel;
    ndone = 0;
    step(1'b1, 1'b0, 8'd99, 1'b0, o, e, c);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 8'd0, 1'($urandom_range(0, 1)), o, e, c);
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL disabled_cycle cyc=%0d got=%h exp=%h", c, o, e); end
      if (o[1] || o[2]) ndone++;
    end
    n_checks++;
    if (ndone !== 0 || buf_sel !== b) begin
      n_fail++; $display("FAIL disabled_idle got=%0d/%b exp=0/%b", ndone, buf_sel, b);
    end
  endtask

  task automatic test_back_to_back();
    logic [25:0] o, e;
    int c, t0, t2, ndone, novr;
    logic b0;
    bit fin;
    b0 = m_buf; ndone = 0; novr = 0; fin = 1'b0;
    step(1'b1, 1'b1, 8'd50, 1'b0, o, e, t0);
    for (int i = 0; i < 2000 && !(m_mode == M_PIX && m_k == 400); i++) begin
      step(1'b0, 1'b1, 8'd0, 1'b0, o, e, c);
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL abort_pass1 cyc=%0d got=%h exp=%h", c, o, e); end
      if (o[1]) ndone++;
    end
    step(1'b1, 1'b1, 8'd77, 1'b0, o, e, t2);
    n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL abort_restart cyc=%0d got=%h exp=%h", t2, o, e); end
    for (int i = 0; i < 4 * L + PC + 100 && !fin; i++) begin
      step(1'b0, 1'b1, 8'd0, 1'b0, o, e, c);
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL abort_pass2 cyc=%0d got=%h exp=%h", c, o, e); end
      if (o[0]) novr++;
      if (i == 0) begin
        n_checks++;
        if (o[0] !== 1'b1 || o[25:18] !== 8'd0) begin
          n_fail++; $display("FAIL abort_overrun got=%b/%0d exp=1/0", o[0], o[25:18]);
        end
      end
      if (o[1]) begin
        ndone++;
        n_checks++;
        if (c !== t2 + PC + 4 * L + 1) begin
          n_fail++; $display("FAIL abort_done_time cyc=%0d exp=%0d", c, t2 + PC + 4 * L + 1);
        end
      end
      if (ndone > 0 && m_mode == M_IDLE) fin = 1'b1;
    end
    n_checks++;
    if (!fin || ndone !== 1 || novr !== 1) begin
      n_fail++; $display("FAIL abort_counts got=done%0d/ovr%0d exp=done1/ovr1", ndone, novr);
    end
    n_checks++;
    if (buf_sel !== b0 || line_num !== 8'd77) begin
      n_fail++; $display("FAIL abort_latch got=%b/%0d exp=%b/77", buf_sel, line_num, b0);
    end
  endtask

  task automatic test_abort_disable();
    logic [25:0] o, e;
    int c;
    step(1'b1, 1'b1, 8'd12, 1'b0, o, e, c);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 8'd0, 1'b0, o, e, c);
    step(1'b1, 1'b0, 8'd13, 1'b0, o, e, c);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 8'd0, 1'b0, o, e, c);
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL abort_disable cyc=%0d got=%h exp=%h", c, o, e); end
    end
  endtask

  task automatic test_reset_mid();
    logic [25:0] o, e;
    int c;
    step(1'b1, 1'b1, 8'd90, 1'b0, o, e, c);
    for (int i = 0; i < 2000 && !(m_mode == M_PIX && m_k == 202); i++)
      step(1'b0, 1'b1, 8'd0, 1'b0, o, e, c);
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (obs_vec() !== 26'h0000100) begin
      n_fail++; $display("FAIL reset_mid got=%h exp=%h", obs_vec(), 26'h0000100);
    end
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 8'd0, 1'b0, o, e, c);
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL reset_mid_idle cyc=%0d got=%h exp=%h", c, o, e); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_stall();
    test_disabled();
    test_back_to_back();
    test_abort_disable();
    test_random_stall();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
